// File: rtl/mips_pkg.sv
// Shared Mini-MIPS datapath types and constants.
package mips_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_DEPTH = 32;

  // Per-request read latency select
  localparam logic RF_LAT_1 = 1'b0;
  localparam logic RF_LAT_2 = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/mips_regfile_2r1w_if.sv
// Request/response bundle for the 2-read/1-write register file.
interface mips_regfile_2r1w_if #(
  parameter int unsigned WIDTH  = mips_pkg::RF_WIDTH,
  parameter int unsigned ADDR_W = 5
);

  logic              clr_req;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re;
  logic              lat_mode;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic              rd_ready;
  logic              rvalid;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              busy;

  modport master (
    output clr_req, we, waddr, wdata, re, lat_mode, raddr_a, raddr_b,
    input  rd_ready, rvalid, rdata_a, rdata_b, busy
  );

  modport slave (
    input  clr_req, we, waddr, wdata, re, lat_mode, raddr_a, raddr_b,
    output rd_ready, rvalid, rdata_a, rdata_b, busy
  );

endinterface

// File: rtl/mips_rf_rdpipe.sv
// Read return pipeline: stage1 holds accepted requests and their mode bit,
// the output register presents 1-cycle requests directly and 2-cycle ones from stage1.
module mips_rf_rdpipe
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             s1_valid_o,
  output logic             s1_mode_o,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q,  s1_mode_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q,     out_a_d;
  logic [WIDTH-1:0] out_b_q,     out_b_d;

  // Output data holds whenever nothing retires, so rdata never goes stale-to-X
  always_comb begin
    s1_valid_d  = acc_i;
    s1_mode_d   = s1_mode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = 1'b0;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    if (acc_i) begin
      s1_mode_d = mode_i;
      s1_a_d    = data_a_i;
      s1_b_d    = data_b_i;
    end
    // rd_ready upstream guarantees these two never retire in the same cycle
    if (s1_valid_q && (s1_mode_q == RF_LAT_2)) begin
      out_valid_d = 1'b1;
      out_a_d     = s1_a_q;
      out_b_d     = s1_b_q;
    end else if (acc_i && (mode_i == RF_LAT_1)) begin
      out_valid_d = 1'b1;
      out_a_d     = data_a_i;
      out_b_d     = data_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= RF_LAT_1;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign s1_mode_o  = s1_mode_q;
  assign rvalid_o   = out_valid_q;
  assign rdata_a_o  = out_a_q;
  assign rdata_b_o  = out_b_q;

endmodule

// File: rtl/mips_regfile_2r1w.sv
// Mini-MIPS 2-read/1-write register file with write-to-read bypass,
// per-request 1/2-cycle read latency and a multi-cycle clear sweep.
module mips_regfile_2r1w
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1
) (
  input logic                clk,
  input logic                rst,
  mips_regfile_2r1w_if.slave bus
);

  typedef logic [ADDR_W:0] addr_x_t;
  localparam addr_x_t           DEPTH_X  = addr_x_t'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_port(
    input logic [ADDR_W-1:0] a,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic [WIDTH-1:0]  stored
  );
    if (!addr_ok(a))             return '0;
    else if (wr_ok && (wa == a)) return wd;
    else                         return stored;
  endfunction

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WIDTH-1:0]  mem_wdata_c;
  logic              idle_c;
  logic              wr_ok_c;
  logic              rd_ready_c;
  logic              rd_acc_c;
  logic [WIDTH-1:0]  rd_a_c;
  logic [WIDTH-1:0]  rd_b_c;
  logic              s1_valid;
  logic              s1_mode;

  assign idle_c   = (state_q == IDLE) && !rst;
  assign wr_ok_c  = bus.we && idle_c && addr_ok(bus.waddr);

  // A 1-cycle request behind a 2-cycle one would retire in the same cycle
  assign rd_ready_c = (state_q == IDLE) && !(s1_valid && (s1_mode == RF_LAT_2)
                                             && (bus.lat_mode == RF_LAT_1));
  assign rd_acc_c   = bus.re && rd_ready_c && !rst;

  // Next state, sweep pointer and the single storage write port
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.waddr;
    mem_wdata_c = bus.wdata;
    if (rst) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
          end
        end
        CLEAR: begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == LAST_PTR) begin
            state_d   = IDLE;
            clr_ptr_d = '0;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
    if (state_q == CLEAR) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_ptr_q;
      mem_wdata_c = '0;
    end else if (wr_ok_c) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign rd_a_c = rd_port(bus.raddr_a, wr_ok_c, bus.waddr, bus.wdata, mem_q[bus.raddr_a]);
  assign rd_b_c = rd_port(bus.raddr_b, wr_ok_c, bus.waddr, bus.wdata, mem_q[bus.raddr_b]);

  mips_rf_rdpipe #(
    .WIDTH (WIDTH)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .acc_i      (rd_acc_c),
    .mode_i     (bus.lat_mode),
    .data_a_i   (rd_a_c),
    .data_b_i   (rd_b_c),
    .s1_valid_o (s1_valid),
    .s1_mode_o  (s1_mode),
    .rvalid_o   (bus.rvalid),
    .rdata_a_o  (bus.rdata_a),
    .rdata_b_o  (bus.rdata_b)
  );

  assign bus.rd_ready = rd_ready_c;
  assign bus.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_mips_regfile_2r1w.sv
// Self-checking bench for mips_regfile_2r1w: vector table plus clear/reset sequences,
// read results matched against a queue of expected responses with their due cycle.
module tb_mips_regfile_2r1w;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int          NV = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_regfile_2r1w_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  mips_regfile_2r1w #(
    .WIDTH    (W),
    .DEPTH    (D),
    .ADDR_W   (AW),
    .ZERO_REG (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rst;
    logic          clr;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          re;
    logic          lat;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          acc;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           due;
  } exp_t;

  exp_t sb[$];
  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                              input logic re, input logic lat,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic acc, input logic [W-1:0] ea, input logic [W-1:0] eb);
    vec_t v;
    v.rst = 1'b0; v.clr = 1'b0;
    v.we  = we;   v.wa  = wa;  v.wd = wd;
    v.re  = re;   v.lat = lat; v.ra = ra; v.rb = rb;
    v.acc = acc;  v.ea  = ea;  v.eb = eb;
    return v;
  endfunction

  // Results retire in order; each must land exactly on its due cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_unexpected: got rvalid=1 with a=%0h, expected no pending result (cycle %0d)",
                 bus.rdata_a, cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata_a", bus.rdata_a, e.a);
        chk("rdata_b", bus.rdata_b, e.b);
        chk("rvalid_cycle", W'(cyc), W'(e.due));
      end
    end
  end

  task automatic drive(input vec_t v, input string tag, input bit push);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    bus.clr_req  = v.clr;
    bus.we       = v.we;
    bus.waddr    = v.wa;
    bus.wdata    = v.wd;
    bus.re       = v.re;
    bus.lat_mode = v.lat;
    bus.raddr_a  = v.ra;
    bus.raddr_b  = v.rb;
    #1;
    if (v.re && !v.rst) begin
      chk({tag, "_rd_ready"}, W'(bus.rd_ready), W'(v.acc));
      if (push && (bus.rd_ready === 1'b1)) begin
        e.a   = v.ea;
        e.b   = v.eb;
        e.due = cyc + 1 + int'(v.lat);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0), "idle", 1'b0);
  endtask

  // Counts busy cycles while hammering we/re/clr_req, which must all be ignored
  task automatic sweep_count(input string tag, input int exp_n, input bit chk_rst);
    int n = 0;
    bit rdy_seen = 1'b0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (chk_rst && (n == 0)) begin
        chk({tag, "_rst_rvalid"},  W'(bus.rvalid), 32'h0);
        chk({tag, "_rst_rdata_a"}, bus.rdata_a,    32'h0);
        chk({tag, "_rst_rdata_b"}, bus.rdata_b,    32'h0);
      end
      rst = 1'b0;
      if ((bus.busy === 1'b1) && (n < 200)) begin
        n++;
        bus.clr_req = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hBAD0BAD0;
        bus.re = 1'b1; bus.lat_mode = 1'b0; bus.raddr_a = 5'd3; bus.raddr_b = 5'd3;
        #1;
        if (bus.rd_ready !== 1'b0) rdy_seen = 1'b1;
      end else begin
        bus.clr_req = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        done = 1'b1;
      end
    end
    chk({tag, "_busy_cycles"},   W'(n),        W'(exp_n));
    chk({tag, "_rd_ready_busy"}, W'(rdy_seen), 32'h0);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() > 0) && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drain", W'(sb.size()), 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    vec_t v;
    bus.clr_req = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re = 1'b0; bus.lat_mode = 1'b0; bus.raddr_a = '0; bus.raddr_b = '0;

    tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0);
    tbl[2]  = mk(1'b1, 5'd0, 32'h1234,     1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 5'd5, 1'b1, 32'h0, 32'hDEADBEEF);
    tbl[4]  = mk(1'b1, 5'd7, 32'h55AA,     1'b1, 1'b1, 5'd7, 5'd5, 1'b1, 32'h55AA, 32'hDEADBEEF);
    tbl[5]  = mk(1'b1, 5'd7, 32'h1111,     1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 32'h1111, 32'h1111);
    tbl[7]  = mk(1'b1, 5'd1, 32'h11,       1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    tbl[8]  = mk(1'b1, 5'd2, 32'h22,       1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 32'h11, 32'h22);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd2, 5'd1, 1'b0, 32'h22, 32'h11);
    tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 32'h22, 32'h11);
    tbl[12] = mk(1'b1, 5'd0, 32'hFFFF,     1'b1, 1'b0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 32'hDEADBEEF, 32'h11);
    tbl[14] = mk(1'b1, 5'd5, 32'hCAFE,     1'b1, 1'b1, 5'd2, 5'd7, 1'b1, 32'h22, 32'h1111);
    tbl[15] = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5, 5'd5, 1'b0, 32'hCAFE, 32'hCAFE);
    tbl[16] = mk(1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 32'hCAFE, 32'hCAFE);
    tbl[17] = mk(1'b1, 5'd9, 32'hAB,       1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 32'hAB, 32'hAB);

    // Power-on reset sweep, then every entry must read zero
    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    v.rst = 1'b1;
    drive(v, "por", 1'b0);
    sweep_count("por", 32, 1'b1);
    for (int i = 0; i < 32; i++) begin
      drive(mk(1'b0, 5'd0, 32'h0, 1'b1, (i >= 16), AW'(i), AW'(31 - i), 1'b1, 32'h0, 32'h0),
            $sformatf("rd_all%0d", i), 1'b1);
    end
    idle(3);

    for (int i = 0; i < NV; i++) drive(tbl[i], $sformatf("vec%0d", i), 1'b1);
    idle(4);
    @(negedge clk);
    chk("hold_rvalid",  W'(bus.rvalid), 32'h0);
    chk("hold_rdata_a", bus.rdata_a,    32'hAB);
    chk("hold_rdata_b", bus.rdata_b,    32'hAB);
    drain();

    // Soft clear accepted alongside a 2-cycle read of the old contents
    v = mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd5, 5'd2, 1'b1, 32'hCAFE, 32'h22);
    v.clr = 1'b1;
    drive(v, "clr_rd", 1'b1);
    sweep_count("clr", 32, 1'b0);
    drive(mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 5'd9, 1'b1, 32'h0, 32'h0), "post_clr", 1'b1);
    idle(3);
    drain();

    // Reset kills a read still sitting in stage1
    drive(mk(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0), "wr4", 1'b0);
    v = mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 32'h44, 32'h44);
    v.clr = 1'b1;
    drive(v, "rst_rd", 1'b0);
    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    v.rst = 1'b1;
    drive(v, "rst_rd_rst", 1'b0);
    sweep_count("rst_read", 32, 1'b1);

    // Reset at sweep cycle 10 restarts the full sweep
    drive(mk(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0), "wr4b", 1'b0);
    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    v.clr = 1'b1;
    drive(v, "clr2", 1'b0);
    idle(10);
    chk("mid_sweep_busy", W'(bus.busy), 32'h1);
    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    v.rst = 1'b1;
    drive(v, "mid_sweep_rst", 1'b0);
    sweep_count("mid_sweep", 32, 1'b1);
    drive(mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd4, 5'd3, 1'b1, 32'h0, 32'h0), "post_rst", 1'b1);
    idle(3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
